// File: rtl/psum_wb_arb_pkg.sv
// Shared definitions for the PSUM write-back arbiter: beat width, FSM encoding, burst counter width.
// The optional output tag port is controlled by the PSUMARB_TAG_EN macro.
`ifndef BUSWIDTH_PSUM
`define BUSWIDTH_PSUM 32
`endif

package psum_wb_arb_pkg;

  localparam int PSUM_W = `BUSWIDTH_PSUM;

  // Wide enough to hold BURST_LEN up to 16.
  localparam int CNT_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_wb_arb_if.sv
// Requester-side and GB-side handshake bundle of the PSUM arbiter.
// PSUMGB_tag exists only when PSUMARB_TAG_EN is defined.
interface psum_wb_arb_if
  import psum_wb_arb_pkg::*;
#(
  parameter int NUM_REQ = 48,
  parameter int DATA_W  = `BUSWIDTH_PSUM
);

  localparam int TAG_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]        PSUMARB_val;
  logic [DATA_W*NUM_REQ-1:0] PSUMARB_data;
  logic [NUM_REQ-1:0]        ARBPSUM_rdy;
  logic                      PSUMGB_val;
  logic [DATA_W-1:0]         PSUMGB_data;
  logic                      GBPSUM_rdy;
`ifdef PSUMARB_TAG_EN
  logic [TAG_W-1:0]          PSUMGB_tag;
`endif

  modport slave (
    input  PSUMARB_val,
    input  PSUMARB_data,
    input  GBPSUM_rdy,
    output ARBPSUM_rdy,
    output PSUMGB_val,
`ifdef PSUMARB_TAG_EN
    output PSUMGB_tag,
`endif
    output PSUMGB_data
  );

  modport master (
    output PSUMARB_val,
    output PSUMARB_data,
    output GBPSUM_rdy,
    input  ARBPSUM_rdy,
    input  PSUMGB_val,
`ifdef PSUMARB_TAG_EN
    input  PSUMGB_tag,
`endif
    input  PSUMGB_data
  );

endinterface

// File: rtl/psum_wb_arb_rr_sel.sv
// Round-robin priority selector: first requester at or after ptr+1 (wrapping) wins.
module rr_sel #(
  parameter int N     = 48,
  parameter int IDX_W = 6
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan farthest-first so the nearest requester after ptr overwrites the result last.
  always_comb begin
    int sum_s;
    int pos_s;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      sum_s = int'(ptr_i) + k;
      pos_s = (sum_s >= N) ? (sum_s - N) : sum_s;
      idx_o = req_i[pos_s] ? IDX_W'(pos_s) : idx_o;
      any_o = any_o | req_i[pos_s];
    end
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = any_o && (idx_o == IDX_W'(i));
    end
  end

endmodule

// File: rtl/psum_wb_arb.sv
// PSUM write-back arbiter: round-robin grant, BURST_LEN-beat lock, single registered output slot.
// Defining PSUMARB_TAG_EN adds PSUMGB_tag carrying the source index of each output beat.
module psum_wb_arb
  import psum_wb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 48,
  parameter int DATA_W    = `BUSWIDTH_PSUM,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  psum_wb_arb_if.slave  bus
);

  localparam int                IDX_W     = idx_width(NUM_REQ);
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_val_q, out_val_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
`ifdef PSUMARB_TAG_EN
  logic [IDX_W-1:0]   tag_q, tag_d;
`endif

  logic [NUM_REQ-1:0] rr_gnt_s;
  logic [NUM_REQ-1:0] rdy_s;
  logic [IDX_W-1:0]   rr_idx_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic               rr_any_s;
  logic               can_load_s;
  logic               hs_s;

  rr_sel #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req_i (bus.PSUMARB_val),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt_s),
    .idx_o (rr_idx_s),
    .any_o (rr_any_s)
  );

  assign can_load_s = ~out_val_q | bus.GBPSUM_rdy;

  // Grant FSM: round-robin in IDLE, locked to ptr in LOCK until the burst completes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rdy_s     = '0;
    hs_s      = 1'b0;
    sel_idx_s = ptr_q;
    case (state_q)
      IDLE: begin
        sel_idx_s = rr_idx_s;
        if (can_load_s) begin
          rdy_s = rr_gnt_s;
          hs_s  = rr_any_s;
        end else begin
          rdy_s = '0;
          hs_s  = 1'b0;
        end
        if (hs_s) begin
          ptr_d = rr_idx_s;
          if (BURST_LEN > 1) begin
            state_d = LOCK;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCK: begin
        sel_idx_s = ptr_q;
        if (can_load_s) begin
          rdy_s[ptr_q] = 1'b1;
          hs_s         = bus.PSUMARB_val[ptr_q];
        end else begin
          rdy_s = '0;
          hs_s  = 1'b0;
        end
        if (hs_s) begin
          if ((cnt_q + CNT_W'(1)) == BURST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = LOCK;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = LOCK;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output slot: take the granted beat when free or draining, otherwise hold.
  always_comb begin
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
`ifdef PSUMARB_TAG_EN
    tag_d      = tag_q;
`endif
    if (can_load_s) begin
      out_val_d = hs_s;
      if (hs_s) begin
        out_data_d = bus.PSUMARB_data[DATA_W*sel_idx_s +: DATA_W];
`ifdef PSUMARB_TAG_EN
        tag_d      = sel_idx_s;
`endif
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_val_d = out_val_q;
    end
  end

  // State and output registers; ptr resets to the last index so index 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= LAST_IDX;
      cnt_q      <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
`ifdef PSUMARB_TAG_EN
      tag_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
`ifdef PSUMARB_TAG_EN
      tag_q      <= tag_d;
`endif
    end
  end

  // Ready is combinational for 1-cycle latency, forced low while reset is held.
  assign bus.ARBPSUM_rdy = rst ? '0 : rdy_s;
  assign bus.PSUMGB_val  = out_val_q;
  assign bus.PSUMGB_data = out_data_q;
`ifdef PSUMARB_TAG_EN
  assign bus.PSUMGB_tag  = tag_q;
`endif

endmodule

// File: tb/tb_psum_wb_arb.sv
// Scoreboard bench for psum_wb_arb: BURST_LEN=4 instance for the main scenarios, BURST_LEN=1 for the sweep.
`ifndef BUSWIDTH_PSUM
`define BUSWIDTH_PSUM 32
`endif

module tb_psum_wb_arb;
  import psum_wb_arb_pkg::*;

  localparam int NR = 48;
  localparam int DW = `BUSWIDTH_PSUM;

  typedef struct {
    int idx;
    int seq;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  seq_clr;
  int    seq_a [NR];
  int    seq_b [NR];
  beat_t exp_a [$];
  beat_t exp_b [$];
  int    n_checks = 0;
  int    n_pass   = 0;

  always #5 clk = ~clk;

  psum_wb_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) ifa ();
  psum_wb_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) ifb ();

  psum_wb_arb #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  psum_wb_arb #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  function automatic logic [DW-1:0] make_beat(input int idx, input int seq);
    logic [31:0] w;
    w = {idx[7:0], 8'hA5, seq[15:0]};
    return DW'(w);
  endfunction

  // Each source presents its index and a per-source sequence number.
  for (genvar g = 0; g < NR; g++) begin : g_src
    assign ifa.PSUMARB_data[DW*g +: DW] = make_beat(g, seq_a[g]);
    assign ifb.PSUMARB_data[DW*g +: DW] = make_beat(g, seq_b[g]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (seq_clr) begin
        seq_a[i] <= 0;
        seq_b[i] <= 0;
      end else begin
        if (ifa.PSUMARB_val[i] && ifa.ARBPSUM_rdy[i]) seq_a[i] <= seq_a[i] + 1;
        if (ifb.PSUMARB_val[i] && ifb.ARBPSUM_rdy[i]) seq_b[i] <= seq_b[i] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_a(input int idx, input int seq0, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.idx = idx;
      b.seq = seq0 + k;
      exp_a.push_back(b);
    end
  endtask

  // Monitor A: every accepted output beat must match the head of the expected queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst === 1'b0 && ifa.PSUMGB_val && ifa.GBPSUM_rdy) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_beat: got %0h expected none", ifa.PSUMGB_data);
      end else begin
        e = exp_a.pop_front();
        check("a_beat_data", ifa.PSUMGB_data, make_beat(e.idx, e.seq));
`ifdef PSUMARB_TAG_EN
        check("a_beat_tag", ifa.PSUMGB_tag, e.idx);
`endif
      end
    end
  end

  // Monitor B: same scoreboard for the single-beat instance.
  always @(negedge clk) begin
    beat_t e;
    if (rst === 1'b0 && ifb.PSUMGB_val && ifb.GBPSUM_rdy) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_beat: got %0h expected none", ifb.PSUMGB_data);
      end else begin
        e = exp_b.pop_front();
        check("b_beat_data", ifb.PSUMGB_data, make_beat(e.idx, e.seq));
`ifdef PSUMARB_TAG_EN
        check("b_beat_tag", ifb.PSUMGB_tag, e.idx);
`endif
      end
    end
  end

  // Ready protocol: at most one bit, none while the output slot is stalled.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("a_rdy_onehot", $onehot0(ifa.ARBPSUM_rdy), 1);
      check("b_rdy_onehot", $onehot0(ifb.ARBPSUM_rdy), 1);
      if (ifa.PSUMGB_val && !ifa.GBPSUM_rdy) check("a_rdy_blocked", ifa.ARBPSUM_rdy, 0);
    end
  end

  initial begin
    beat_t b;
    rst = 1'b1;
    seq_clr = 1'b1;
    ifa.PSUMARB_val = '0;
    ifb.PSUMARB_val = '0;
    ifa.GBPSUM_rdy = 1'b1;
    ifb.GBPSUM_rdy = 1'b1;
    step(2);

    // Reset values while rst is held
    check("rst_a_val", ifa.PSUMGB_val, 0);
    check("rst_a_data", ifa.PSUMGB_data, 0);
    check("rst_a_rdy", ifa.ARBPSUM_rdy, 0);
    check("rst_b_val", ifb.PSUMGB_val, 0);
    check("rst_b_data", ifb.PSUMGB_data, 0);
`ifdef PSUMARB_TAG_EN
    check("rst_a_tag", ifa.PSUMGB_tag, 0);
`endif
    rst = 1'b0;
    seq_clr = 1'b0;

    // Two requesters 0 and 5: bursts 0,5,0 back to back
    push_a(0, 0, 4);
    push_a(5, 0, 4);
    push_a(0, 4, 4);
    ifa.PSUMARB_val[0] = 1'b1;
    ifa.PSUMARB_val[5] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check("t1_no_gap", ifa.PSUMGB_val, 1);
    end
    ifa.PSUMARB_val = '0;
    step(3);

    // Output stall for 3 cycles with a beat held in the slot
    seq_clr = 1'b1;
    step(1);
    seq_clr = 1'b0;
    push_a(2, 0, 4);
    ifa.PSUMARB_val[2] = 1'b1;
    step(1);
    check("t3_first_val", ifa.PSUMGB_val, 1);
    ifa.GBPSUM_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t3_stall_val", ifa.PSUMGB_val, 1);
      check("t3_stall_data", ifa.PSUMGB_data, make_beat(2, 0));
      check("t3_stall_rdy", ifa.ARBPSUM_rdy, 0);
    end
    ifa.GBPSUM_rdy = 1'b1;
    step(3);
    ifa.PSUMARB_val = '0;
    step(3);

    // Locked to 3 while its val drops and 4 requests
    seq_clr = 1'b1;
    step(1);
    seq_clr = 1'b0;
    push_a(3, 0, 4);
    push_a(4, 0, 4);
    ifa.PSUMARB_val[3] = 1'b1;
    step(1);
    ifa.PSUMARB_val[3] = 1'b0;
    ifa.PSUMARB_val[4] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1);
      check("t4_lock_gap_rdy", ifa.ARBPSUM_rdy, NR'(1) << 3);
    end
    ifa.PSUMARB_val[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1);
      check("t4_lock_rdy", ifa.ARBPSUM_rdy, NR'(1) << 3);
    end
    step(1);
    ifa.PSUMARB_val[3] = 1'b0;
    #1;
    check("t4_next_rdy", ifa.ARBPSUM_rdy, NR'(1) << 4);
    step(4);
    ifa.PSUMARB_val = '0;
    step(3);

    // Wrap: only 47 requests right after reset
    rst = 1'b1;
    seq_clr = 1'b1;
    ifa.PSUMARB_val[47] = 1'b1;
    step(2);
    check("t2_rst_rdy", ifa.ARBPSUM_rdy, 0);
    rst = 1'b0;
    seq_clr = 1'b0;
    push_a(47, 0, 4);
    #1;
    check("t2_wrap_rdy", ifa.ARBPSUM_rdy, NR'(1) << 47);
    step(4);
    ifa.PSUMARB_val = '0;
    step(3);

    // Reset after beat 2 of a burst discards the held beat
    seq_clr = 1'b1;
    step(1);
    seq_clr = 1'b0;
    push_a(1, 0, 1);
    ifa.PSUMARB_val[1] = 1'b1;
    step(2);
    rst = 1'b1;
    #1;
    check("t5_rst_val", ifa.PSUMGB_val, 0);
    check("t5_rst_data", ifa.PSUMGB_data, 0);
    check("t5_rst_rdy", ifa.ARBPSUM_rdy, 0);
    push_a(0, 0, 4);
    push_a(1, 2, 4);
    ifa.PSUMARB_val[0] = 1'b1;
    step(2);
    rst = 1'b0;
    #1;
    check("t5_first_grant", ifa.ARBPSUM_rdy, NR'(1));
    step(8);
    ifa.PSUMARB_val = '0;
    step(3);

    // BURST_LEN=1 sweep with every requester valid
    seq_clr = 1'b1;
    step(1);
    seq_clr = 1'b0;
    for (int i = 0; i < NR; i++) begin
      b.idx = i;
      b.seq = 0;
      exp_b.push_back(b);
    end
    b.idx = 0;
    b.seq = 1;
    exp_b.push_back(b);
    ifb.PSUMARB_val = '1;
    for (int k = 0; k < NR + 1; k++) begin
      step(1);
      check("t6_one_per_cycle", ifb.PSUMGB_val, 1);
    end
    ifb.PSUMARB_val = '0;
    step(3);

    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
